// File: rtl/hazard_pkg.sv
// Shared types for the hazard controller: forward selects,
// FSM states and the stall/flush control bundle.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    HZ_RUN,
    HZ_MEM_WAIT,
    HZ_REDIRECT
  } hz_state_t;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
  } hz_ctl_t;

  localparam hz_ctl_t CTL_NONE = 6'b0000_00;
  localparam hz_ctl_t CTL_MEM  = 6'b1111_00;
  localparam hz_ctl_t CTL_MP   = 6'b0000_11;
  localparam hz_ctl_t CTL_LU   = 6'b1100_01;
  localparam hz_ctl_t CTL_REDIR = 6'b0000_10;

  function automatic logic is_load_use(
    input logic       mem_read_e,
    input logic [4:0] rd_e,
    input logic [4:0] rs1_d,
    input logic [4:0] rs2_d
  );
    return mem_read_e && (rd_e != 5'd0) &&
           ((rd_e == rs1_d) || (rd_e == rs2_d));
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_select.sv
// Operand forward select for one EX source register.
// MEM-stage result has priority over WB; x0 never forwards.
module fwd_select
  import hazard_pkg::*;
(
  input  logic [4:0] rs_e,
  input  logic [4:0] rd_m,
  input  logic       reg_write_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_w,
  output fwd_sel_t   sel
);

  // Priority pick: MEM, then WB, else register file.
  always_comb begin
    sel = FWD_RF;
    if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs_e))
      sel = FWD_MEM;
    else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs_e))
      sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, redirect, dmem wait.
// HAZARD_PERF_EN adds stall/flush/load-use perf counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REDIRECT_CYCLES = 1,
  parameter int MAX_WAIT        = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_d,
  input  logic [4:0]  rs2_d,
  input  logic [4:0]  rs1_e,
  input  logic [4:0]  rs2_e,
  input  logic [4:0]  rd_e,
  input  logic        mem_read_e,
  input  logic [4:0]  rd_m,
  input  logic        reg_write_m,
  input  logic [4:0]  rd_w,
  input  logic        reg_write_w,
  input  logic        mispredict_e,
  input  logic        dmem_busy_m,
  output logic        stall_f,
  output logic        stall_d,
  output logic        stall_e,
  output logic        stall_m,
  output logic        flush_d,
  output logic        flush_e,
  output logic [1:0]  forward_a_e,
  output logic [1:0]  forward_b_e,
`ifdef HAZARD_PERF_EN
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_loaduse_cnt,
`endif
  output logic        mem_timeout
);

  localparam logic [15:0] WAIT_MAX  = 16'(MAX_WAIT);
  localparam logic [15:0] REDIR_LD  = 16'(REDIRECT_CYCLES - 1);

  hz_state_t   state_q, state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [15:0] redir_cnt_q, redir_cnt_d;
  logic        timeout_q, timeout_d;
  hz_ctl_t     ctl;
  logic        run_path;
  logic        acc_mp;
  logic        acc_lu;
  logic        load_use;
  fwd_sel_t    fwd_a, fwd_b;

  fwd_select u_fwd_a (
    .rs_e        (rs1_e),
    .rd_m        (rd_m),
    .reg_write_m (reg_write_m),
    .rd_w        (rd_w),
    .reg_write_w (reg_write_w),
    .sel         (fwd_a)
  );

  fwd_select u_fwd_b (
    .rs_e        (rs2_e),
    .rd_m        (rd_m),
    .reg_write_m (reg_write_m),
    .rd_w        (rd_w),
    .reg_write_w (reg_write_w),
    .sel         (fwd_b)
  );

  assign load_use = is_load_use(mem_read_e, rd_e, rs1_d, rs2_d);

  // Next state, counters and stall/flush controls.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    redir_cnt_d = redir_cnt_q;
    timeout_d   = timeout_q;
    ctl         = CTL_NONE;
    run_path    = 1'b0;
    acc_mp      = 1'b0;
    acc_lu      = 1'b0;

    unique case (state_q)
      HZ_RUN: run_path = 1'b1;
      HZ_MEM_WAIT: begin
        if (dmem_busy_m) begin
          ctl = CTL_MEM;
          if (wait_cnt_q == WAIT_MAX)
            timeout_d = 1'b1;
          else
            wait_cnt_d = wait_cnt_q + 16'd1;
        end else begin
          // Exit cycle behaves exactly like RUN.
          run_path   = 1'b1;
          wait_cnt_d = '0;
        end
      end
      HZ_REDIRECT: begin
        if (dmem_busy_m) begin
          run_path    = 1'b1;
          redir_cnt_d = '0;
        end else begin
          ctl = CTL_REDIR;
          if (mispredict_e) begin
            ctl.flush_e = 1'b1;
            acc_mp      = 1'b1;
            redir_cnt_d = REDIR_LD;
          end else if (redir_cnt_q <= 16'd1) begin
            redir_cnt_d = '0;
            state_d     = HZ_RUN;
          end else begin
            redir_cnt_d = redir_cnt_q - 16'd1;
          end
        end
      end
      default: state_d = HZ_RUN;
    endcase

    if (run_path) begin
      state_d = HZ_RUN;
      if (dmem_busy_m) begin
        ctl        = CTL_MEM;
        state_d    = HZ_MEM_WAIT;
        wait_cnt_d = 16'd1;
      end else if (mispredict_e) begin
        ctl    = CTL_MP;
        acc_mp = 1'b1;
        if (REDIRECT_CYCLES > 1) begin
          state_d     = HZ_REDIRECT;
          redir_cnt_d = REDIR_LD;
        end
      end else if (load_use) begin
        ctl    = CTL_LU;
        acc_lu = 1'b1;
      end
    end
  end

  // FSM state, wait/redirect counters and sticky timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HZ_RUN;
      wait_cnt_q  <= '0;
      redir_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      redir_cnt_q <= redir_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  // Reset forces every control quiet, even mid-sequence.
  always_comb begin
    stall_f     = ctl.stall_f & ~rst;
    stall_d     = ctl.stall_d & ~rst;
    stall_e     = ctl.stall_e & ~rst;
    stall_m     = ctl.stall_m & ~rst;
    flush_d     = ctl.flush_d & ~rst;
    flush_e     = ctl.flush_e & ~rst;
    forward_a_e = rst ? FWD_RF : fwd_a;
    forward_b_e = rst ? FWD_RF : fwd_b;
    mem_timeout = timeout_q;
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] pstall_q, pstall_d;
  logic [31:0] pflush_q, pflush_d;
  logic [31:0] plu_q, plu_d;

  // Event counters, wrapping modulo 2^32.
  always_comb begin
    pstall_d = pstall_q + {31'd0, stall_f};
    pflush_d = pflush_q + {31'd0, acc_mp};
    plu_d    = plu_q + {31'd0, acc_lu};
  end

  // Perf counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pstall_q <= '0;
      pflush_q <= '0;
      plu_q    <= '0;
    end else begin
      pstall_q <= pstall_d;
      pflush_q <= pflush_d;
      plu_q    <= plu_d;
    end
  end

  assign perf_stall_cnt   = pstall_q;
  assign perf_flush_cnt   = pflush_q;
  assign perf_loaduse_cnt = plu_q;
`endif

endmodule
